// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control logic.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MDU_LAT_MAX = 16;
    // Wide enough to hold MDU_LAT_MAX-2.
    localparam int unsigned CNT_W       = $clog2(MDU_LAT_MAX);

    typedef enum logic [1:0] {
        RUN,
        MDU_WAIT,
        REDIRECT
    } pipe_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. x0 never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // Source match per operand, qualified by whether the operand is read.
    always_comb begin
        rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
        rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
        load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use stalls,
// multi-cycle MDU occupancy of EX and the two-cycle fetch flush on redirect.
// Optional build macro PIPE_PERF_CNT_EN adds stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mdu_i,
    input  logic                  ex_redirect_i,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic                  ex_hold_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           flush_cycles_o
`endif
);

    // A single-cycle MDU never stalls, so ex_mdu is ignored in that case.
    localparam bit              MduEn   = (MDU_LAT >= 2);
    localparam logic [CNT_W-1:0] MduLoad = MduEn ? CNT_W'(MDU_LAT - 2) : '0;

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    load_use_detect u_load_use_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .load_use_o    (load_use)
    );

    // Next-state and pipeline control outputs; reset forces a flush/bubble.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_hold_o      = 1'b0;
        if (rst_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_redirect_i) begin
                        pc_write_o     = 1'b1;
                        if_id_flush_o  = 1'b1;
                        id_ex_bubble_o = 1'b1;
                        state_d        = REDIRECT;
                    end else if (ex_mdu_i && MduEn) begin
                        ex_hold_o = 1'b1;
                        cnt_d     = MduLoad;
                        state_d   = MDU_WAIT;
                    end else if (load_use) begin
                        id_ex_bubble_o = 1'b1;
                    end else begin
                        pc_write_o    = 1'b1;
                        if_id_write_o = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (cnt_q != '0) begin
                        ex_hold_o = 1'b1;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end else begin
                        // Last MDU cycle: let the pipeline advance.
                        pc_write_o    = 1'b1;
                        if_id_write_o = 1'b1;
                        state_d       = RUN;
                    end
                end
                REDIRECT: begin
                    // Discard the wrong-path word from the synchronous imem.
                    pc_write_o    = 1'b1;
                    if_id_flush_o = 1'b1;
                    state_d       = ex_redirect_i ? REDIRECT : RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and MDU occupancy counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_o) begin
                stall_q <= stall_q + 32'd1;
            end
            if (if_id_flush_o) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_cycles_o = flush_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall sequencer for the 5-stage pipeline. Drives the PC write enable, the IF/ID register's write enable and flush, and the ID/EX bubble and hold controls, from hazard information supplied by ID and EX. Covers three events: load-use stalls, multi-cycle MDU occupancy of EX, and the two-cycle fetch flush after an EX-stage redirect. Sits beside the IF/ID and ID/EX pipeline registers in the core top level.

## Interface
- MDU_LAT, 4: cycles an MDU op occupies EX; legal range 1..16.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- id_rs1, id_rs2  input  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1 / rs2
- ex_mem_read  input  1  EX instruction is a load
- ex_rd  input  5  EX destination register
- ex_mdu  input  1  EX holds a multi-cycle MDU op
- ex_redirect  input  1  EX resolved a taken branch or jump; PC target valid this cycle
- pc_write  output  1  PC register load enable
- if_id_write  output  1  IF/ID load enable
- if_id_flush  output  1  IF/ID loads a NOP (takes precedence over if_id_write in the register)
- id_ex_bubble  output  1  ID/EX loads a NOP
- ex_hold  output  1  ID/EX and EX hold their contents

## Operation
- Outputs are combinational from state, counter and inputs.
- FSM states:
  - RUN: normal operation.
  - MDU_WAIT: EX is occupied by an MDU op.
  - REDIRECT: fetch is being flushed after a redirect.
- Event priority in RUN: ex_redirect > ex_mdu > load-use.
- Load-use condition: ex_mem_read && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd)).
- RUN, ex_redirect:
  - Outputs: pc_write=1, if_id_flush=1, id_ex_bubble=1.
  - Next state: REDIRECT.
- RUN, ex_mdu with MDU_LAT ≥ 2:
  - Outputs: pc_write=0, if_id_write=0, ex_hold=1.
  - Counter loads MDU_LAT-2; next state: MDU_WAIT.
- RUN, load-use:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - State remains RUN.
- RUN, no event: pc_write=1, if_id_write=1, all other outputs 0.
- MDU_WAIT, counter ≠ 0:
  - Stall outputs as on MDU entry; counter decrements.
  - ex_redirect and load-use are ignored.
- MDU_WAIT, counter = 0:
  - RUN no-event outputs, so the pipeline advances.
  - Next state: RUN.
  - ex_mdu is ignored in this cycle (it is the same op).
- REDIRECT:
  - Outputs: pc_write=1, if_id_flush=1, id_ex_bubble=0. This discards the wrong-path word returned by the synchronous instruction memory.
  - Next state: RUN, or REDIRECT again if ex_redirect=1.
- MDU_LAT=1: ex_mdu is ignored entirely.
- Counter width: 4 bits.

## Timing
- Reset, asynchronous:
  - State RUN, counter 0.
  - While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0.
- Load-use: exactly 1 stall cycle; the dependent instruction re-evaluates in ID the next cycle with EX holding a bubble, so no repeat stall.
- MDU: op occupies EX for MDU_LAT cycles; MDU_LAT-1 stall cycles; advance on the last.
- Redirect: 2 consecutive if_id_flush cycles (the redirect cycle plus REDIRECT); first correct-path instruction reaches ID on the 3rd cycle.
- Back-to-back MDU ops: the second op's ex_mdu is seen in the cycle after MDU_WAIT exits and starts a new sequence.
- rst asserted mid-MDU_WAIT or mid-REDIRECT: immediate return to RUN, counter cleared.

## Configuration
- PIPE_PERF_CNT_EN defined: adds two output ports, both 32-bit, reset to 0 and wrapping mod 2^32.
  - stall_cycles: counts cycles with pc_write=0 and rst=0.
  - flush_cycles: counts cycles with if_id_flush=1 and rst=0.
- PIPE_PERF_CNT_EN undefined: those ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MDU_WAIT, REDIRECT};
  - REG_ADDR_W = 5;
  - MDU_LAT_MAX = 16.
- One sub-module, load_use_detect: purely combinational comparator producing the load-use condition; reused by the forwarding unit.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (ex_mem_read=0) all enables 1.
- x0 and unused-source filtering: ex_rd=0 matching id_rs1=0, and ex_rd=7 with id_rs2=7 but id_rs2_used=0 → no stall.
- MDU, MDU_LAT=4: ex_mdu held 4 cycles → ex_hold=1 for exactly 3 cycles, pc_write=0 for 3, advance on cycle 4. Back-to-back second op → another 3-cycle stall.
- Redirect: ex_redirect pulse → if_id_flush=1 for 2 cycles, id_ex_bubble=1 only in the first, pc_write=1 throughout. Simultaneous ex_redirect with a load-use match → redirect wins, no stall.
- Async reset: assert rst mid-MDU_WAIT, between clock edges → outputs switch immediately to reset values; after release, state RUN, enables 1.
- With PIPE_PERF_CNT_EN: one load-use, one MDU_LAT=4 op and one redirect → stall_cycles=4, flush_cycles=2.
